// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler sharing one uart_tx between NREQ frame requesters, with bounded retry.
// Optional build macro UART_TX_SCHED_PRIO_EN gives requester 0 fixed absolute priority.
module uart_tx_sched #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned PORTCOUNT = 5,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NREQ-1:0]             req,
  input  logic [2*NREQ-1:0]           req_comma_sel,
  input  logic [NREQ*PORTCOUNT*10-1:0] req_data,
  output logic [NREQ-1:0]             ack,
  output logic [NREQ-1:0]             cmpl,
  output logic [NREQ-1:0]             fail,
  output logic                        tx_start,
  output logic [1:0]                  tx_comma_sel,
  output logic [PORTCOUNT*10-1:0]     tx_data,
  input  logic                        tx_done,
  input  logic                        tx_err,
  output logic                        busy,
  output logic [15:0]                 frame_cnt
);

  localparam int unsigned DW    = PORTCOUNT * 10;
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned RTR_W = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RETRY  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [RTR_W-1:0] retry_q, retry_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  cmpl_q, cmpl_d;
  logic [NREQ-1:0]  fail_q, fail_d;
  logic             tx_start_q, tx_start_d;
  logic [1:0]       comma_q, comma_d;
  logic [DW-1:0]    data_q, data_d;
  logic             busy_q, busy_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [PTR_W-1:0] grant_idx;
  logic [NREQ-1:0]  grant_oh;
  logic [NREQ-1:0]  ptr_oh;
  logic [1:0]       sel_comma;
  logic [DW-1:0]    sel_data;

  // Round-robin: first requester above ptr, else the lowest one at or below ptr.
  always_comb begin
    logic             hi_found;
    logic             lo_found;
    logic [PTR_W-1:0] hi_idx;
    logic [PTR_W-1:0] lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (!hi_found && (PTR_W'(i) > ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = PTR_W'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
`ifdef UART_TX_SCHED_PRIO_EN
    if (req[0]) begin
      grant_idx = '0;
    end
`endif
    grant_oh  = NREQ'(1) << grant_idx;
    ptr_oh    = NREQ'(1) << ptr_q;
    sel_comma = 2'(req_comma_sel >> (32'(grant_idx) * 2));
    sel_data  = DW'(req_data >> (32'(grant_idx) * DW));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    retry_d = retry_q;
    ack_d   = '0;
    cmpl_d  = '0;
    fail_d  = '0;
    comma_d = comma_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          ack_d   = grant_oh;
          comma_d = sel_comma;
          data_d  = sel_data;
          ptr_d   = grant_idx;
          retry_d = '0;
          if (sel_comma == 2'b00) begin
            fail_d = grant_oh;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // The start-pulse cycle still sees the stale tx_err of a previous frame.
        if (!tx_start_q) begin
          if (tx_done) begin
            cmpl_d  = ptr_oh;
            cnt_d   = cnt_q + 16'd1;
            state_d = S_IDLE;
          end else if (tx_err) begin
            if (retry_q < RTR_W'(MAX_RETRY)) begin
              retry_d = retry_q + RTR_W'(1);
              state_d = S_RETRY;
            end else begin
              fail_d  = ptr_oh;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_RETRY: state_d = S_LAUNCH;
      default: state_d = S_IDLE;
    endcase
    tx_start_d = (state_q == S_LAUNCH);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      ptr_q      <= PTR_W'(NREQ - 1);
      retry_q    <= '0;
      ack_q      <= '0;
      cmpl_q     <= '0;
      fail_q     <= '0;
      tx_start_q <= 1'b0;
      comma_q    <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      retry_q    <= retry_d;
      ack_q      <= ack_d;
      cmpl_q     <= cmpl_d;
      fail_q     <= fail_d;
      tx_start_q <= tx_start_d;
      comma_q    <= comma_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ack          = ack_q;
  assign cmpl         = cmpl_q;
  assign fail         = fail_q;
  assign tx_start     = tx_start_q;
  assign tx_comma_sel = comma_q;
  assign tx_data      = data_q;
  assign busy         = busy_q;
  assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (NREQ=3, PORTCOUNT=5, MAX_RETRY=2).
module tb_uart_tx_sched;

  localparam int unsigned NREQ = 3;
  localparam int unsigned PORTCOUNT = 5;
  localparam int unsigned DW = PORTCOUNT * 10;

  logic                 CLK = 1'b0;
  logic                 nRST = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [2*NREQ-1:0]    req_comma_sel = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      ack, cmpl, fail;
  logic                 tx_start;
  logic [1:0]           tx_comma_sel;
  logic [DW-1:0]        tx_data;
  logic                 tx_done = 1'b0;
  logic                 tx_err = 1'b0;
  logic                 busy;
  logic [15:0]          frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int cmpl_cnt = 0;
  int fail_cnt = 0;

  uart_tx_sched #(.NREQ(NREQ), .PORTCOUNT(PORTCOUNT), .MAX_RETRY(2)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .req_comma_sel(req_comma_sel), .req_data(req_data),
    .ack(ack), .cmpl(cmpl), .fail(fail), .tx_start(tx_start), .tx_comma_sel(tx_comma_sel),
    .tx_data(tx_data), .tx_done(tx_done), .tx_err(tx_err), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  // Pulse counters sampled at the edge that ends each pulse.
  always @(posedge CLK) begin
    if (tx_start) start_cnt <= start_cnt + 1;
    if (|cmpl) cmpl_cnt <= cmpl_cnt + 1;
    if (|fail) fail_cnt <= fail_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_slot(input int i, input logic [1:0] sel, input logic [DW-1:0] d);
    req_comma_sel = (req_comma_sel & ~((2*NREQ)'(2'b11) << (2 * i))) | ((2*NREQ)'(sel) << (2 * i));
    req_data = (req_data & ~((NREQ*DW)'({DW{1'b1}}) << (DW * i))) | ((NREQ*DW)'(d) << (DW * i));
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a, output bit ok);
    ok = 1'b0;
    a = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (|ack) begin
        ok = 1'b1;
        a = ack;
        break;
      end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    repeat (2) tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    req = '0;
    repeat (3) tick();
    n_checks++; if (ack !== 3'b000) begin n_errors++; $display("FAIL reset_ack: got %b expected 000", ack); end
    n_checks++; if (cmpl !== 3'b000) begin n_errors++; $display("FAIL reset_cmpl: got %b expected 000", cmpl); end
    n_checks++; if (fail !== 3'b000) begin n_errors++; $display("FAIL reset_fail: got %b expected 000", fail); end
    n_checks++; if (tx_start !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b expected 0", tx_start); end
    n_checks++; if (tx_data !== 50'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (frame_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_cnt: got %h expected 0", frame_cnt); end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] d;
    d = 50'h2AAAA_AAAAA;
    set_slot(1, 2'b11, d);
    req = 3'b010;
    tick();
    n_checks++; if (ack !== 3'b010) begin n_errors++; $display("FAIL single_ack: got %b expected 010", ack); end
    n_checks++; if (tx_start !== 1'b0) begin n_errors++; $display("FAIL single_start_early: got %b expected 0", tx_start); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    req = 3'b000;
    tick();
    n_checks++; if (tx_start !== 1'b1) begin n_errors++; $display("FAIL single_start: got %b expected 1", tx_start); end
    n_checks++; if (tx_data !== d) begin n_errors++; $display("FAIL single_data: got %h expected %h", tx_data, d); end
    n_checks++; if (tx_comma_sel !== 2'b11) begin n_errors++; $display("FAIL single_comma: got %b expected 11", tx_comma_sel); end
    tick();
    n_checks++; if (tx_start !== 1'b0) begin n_errors++; $display("FAIL single_start_width: got %b expected 0", tx_start); end
    tick();
    pulse_done();
    n_checks++; if (cmpl !== 3'b010) begin n_errors++; $display("FAIL single_cmpl: got %b expected 010", cmpl); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL single_cnt: got %0d expected 1", frame_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_idle: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_g[4];
    logic [NREQ-1:0] a;
    logic [DW-1:0] d[3];
    bit ok;
`ifdef UART_TX_SCHED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 0};
`endif
    d[0] = 50'h0_1111_1111;
    d[1] = 50'h2_2222_2222;
    d[2] = 50'h3_3333_3333;
    apply_reset();
    for (int i = 0; i < 3; i++) set_slot(i, 2'b01, d[i]);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL rr_ack_timeout: grant %0d got none expected ack", k); end
      n_checks++; if (a !== (3'b001 << exp_g[k])) begin n_errors++; $display("FAIL rr_order: grant %0d got %b expected %b", k, a, 3'b001 << exp_g[k]); end
      if (k == 3) req = 3'b000;
      wait_start(ok);
      n_checks++; if (tx_data !== d[exp_g[k]]) begin n_errors++; $display("FAIL rr_data: grant %0d got %h expected %h", k, tx_data, d[exp_g[k]]); end
      repeat (4) tick();
      pulse_done();
      n_checks++; if (cmpl !== (3'b001 << exp_g[k])) begin n_errors++; $display("FAIL rr_cmpl: grant %0d got %b expected %b", k, cmpl, 3'b001 << exp_g[k]); end
    end
    n_checks++; if (frame_cnt !== 16'd4) begin n_errors++; $display("FAIL rr_cnt: got %0d expected 4", frame_cnt); end
    tick();
  endtask

  // n_err errors then done (if n_err <= 2) or a drop (n_err == 3); tx_err is cleared only on start.
  task automatic run_retry(input int n_err, input string tag);
    logic [NREQ-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    int s0, c0, f0;
    d = 50'h1_5A5A_C3C3;
    s0 = start_cnt; c0 = cmpl_cnt; f0 = fail_cnt;
    set_slot(0, 2'b10, d);
    req = 3'b001;
    wait_ack(a, ok);
    req = 3'b000;
    for (int l = 0; l < 3; l++) begin
      wait_start(ok);
      tx_err = 1'b0;
      n_checks++; if (!ok) begin n_errors++; $display("FAIL %s_start_timeout: launch %0d got none expected start", tag, l); end
      n_checks++; if (tx_data !== d) begin n_errors++; $display("FAIL %s_data: launch %0d got %h expected %h", tag, l, tx_data, d); end
      tick();
      if (l < n_err) begin
        tx_err = 1'b1;
        tick();
      end else begin
        pulse_done();
      end
    end
    if (n_err < 3) begin
      n_checks++; if (cmpl !== 3'b001) begin n_errors++; $display("FAIL %s_cmpl: got %b expected 001", tag, cmpl); end
    end else begin
      n_checks++; if (fail !== 3'b001) begin n_errors++; $display("FAIL %s_fail: got %b expected 001", tag, fail); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL %s_idle: got %b expected 0", tag, busy); end
    end
    repeat (3) tick();
    n_checks++; if (start_cnt - s0 !== 3) begin n_errors++; $display("FAIL %s_starts: got %0d expected 3", tag, start_cnt - s0); end
    n_checks++; if (cmpl_cnt - c0 !== (n_err < 3 ? 1 : 0)) begin n_errors++; $display("FAIL %s_cmpl_count: got %0d expected %0d", tag, cmpl_cnt - c0, n_err < 3 ? 1 : 0); end
    n_checks++; if (fail_cnt - f0 !== (n_err < 3 ? 0 : 1)) begin n_errors++; $display("FAIL %s_fail_count: got %0d expected %0d", tag, fail_cnt - f0, n_err < 3 ? 0 : 1); end
  endtask

  task automatic test_retry();
    run_retry(2, "retry");
    n_checks++; if (frame_cnt !== 16'd5) begin n_errors++; $display("FAIL retry_cnt: got %0d expected 5", frame_cnt); end
    run_retry(3, "exhaust");
    n_checks++; if (frame_cnt !== 16'd5) begin n_errors++; $display("FAIL exhaust_cnt: got %0d expected 5", frame_cnt); end
  endtask

  // tx_err still high from the dropped frame must not trigger a retry.
  task automatic test_stale_err();
    logic [NREQ-1:0] a;
    bit ok;
    int s0, f0;
    s0 = start_cnt; f0 = fail_cnt;
    tx_err = 1'b1;
    set_slot(1, 2'b01, 50'h0_0000_BEEF);
    req = 3'b010;
    wait_ack(a, ok);
    req = 3'b000;
    wait_start(ok);
    tx_err = 1'b0;
    repeat (2) tick();
    pulse_done();
    n_checks++; if (cmpl !== 3'b010) begin n_errors++; $display("FAIL stale_cmpl: got %b expected 010", cmpl); end
    repeat (3) tick();
    n_checks++; if (start_cnt - s0 !== 1 || fail_cnt - f0 !== 0) begin n_errors++; $display("FAIL stale_counts: got starts %0d fails %0d expected 1 0", start_cnt - s0, fail_cnt - f0); end
  endtask

  task automatic test_invalid_comma();
    int s0;
    s0 = start_cnt;
    set_slot(2, 2'b00, 50'h3_0F0F_0F0F);
    req = 3'b100;
    tick();
    n_checks++; if (ack !== 3'b100) begin n_errors++; $display("FAIL inv_ack: got %b expected 100", ack); end
    n_checks++; if (fail !== 3'b100) begin n_errors++; $display("FAIL inv_fail: got %b expected 100", fail); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL inv_busy: got %b expected 0", busy); end
    n_checks++; if (tx_data !== 50'h3_0F0F_0F0F) begin n_errors++; $display("FAIL inv_capture: got %h expected 30f0f0f0f", tx_data); end
    req = 3'b000;
    repeat (4) tick();
    n_checks++; if (start_cnt - s0 !== 0 || busy !== 1'b0) begin n_errors++; $display("FAIL inv_nostart: got starts %0d busy %b expected 0 0", start_cnt - s0, busy); end
  endtask

  task automatic test_reset_mid_wait();
    logic [NREQ-1:0] a;
    bit ok;
    int c0, f0;
    set_slot(1, 2'b01, 50'h2_DEAD_BEEF);
    req = 3'b010;
    wait_ack(a, ok);
    req = 3'b000;
    wait_start(ok);
    tick();
    c0 = cmpl_cnt; f0 = fail_cnt;
    #2 nRST = 1'b0;
    #1;
    n_checks++; if ({ack, cmpl, fail} !== 9'h0 || tx_start !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL midrst_ctrl: got ack %b cmpl %b fail %b start %b busy %b expected all 0", ack, cmpl, fail, tx_start, busy); end
    n_checks++; if (tx_data !== 50'h0 || tx_comma_sel !== 2'b00) begin n_errors++; $display("FAIL midrst_data: got %h/%b expected 0/00", tx_data, tx_comma_sel); end
    n_checks++; if (frame_cnt !== 16'h0) begin n_errors++; $display("FAIL midrst_cnt: got %0d expected 0", frame_cnt); end
    repeat (2) tick();
    nRST = 1'b1;
    set_slot(0, 2'b11, 50'h1_0000_0001);
    set_slot(2, 2'b11, 50'h1_0000_0003);
    req = 3'b101;
    wait_ack(a, ok);
    n_checks++; if (a !== 3'b001) begin n_errors++; $display("FAIL midrst_grant: got %b expected 001", a); end
    req = 3'b000;
    n_checks++; if (cmpl_cnt - c0 !== 0 || fail_cnt - f0 !== 0) begin n_errors++; $display("FAIL midrst_nopulse: got cmpl %0d fail %0d expected 0 0", cmpl_cnt - c0, fail_cnt - f0); end
    wait_start(ok);
    tick();
    pulse_done();
    n_checks++; if (cmpl !== 3'b001 || frame_cnt !== 16'd1) begin n_errors++; $display("FAIL midrst_frame: got cmpl %b cnt %0d expected 001 1", cmpl, frame_cnt); end
    tick();
  endtask

  task automatic test_wrap_collision();
    logic [NREQ-1:0] a;
    bit ok;
    int s0, f0;
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    s0 = start_cnt; f0 = fail_cnt;
    set_slot(2, 2'b10, 50'h0_1234_5678);
    req = 3'b100;
    wait_ack(a, ok);
    req = 3'b000;
    wait_start(ok);
    tick();
    tx_done = 1'b1;
    tx_err = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_err = 1'b0;
    n_checks++; if (cmpl !== 3'b100) begin n_errors++; $display("FAIL coll_cmpl: got %b expected 100", cmpl); end
    n_checks++; if (frame_cnt !== 16'h0000) begin n_errors++; $display("FAIL wrap_cnt: got %h expected 0000", frame_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL coll_idle: got %b expected 0", busy); end
    repeat (4) tick();
    n_checks++; if (start_cnt - s0 !== 1 || fail_cnt - f0 !== 0) begin n_errors++; $display("FAIL coll_noretry: got starts %0d fails %0d expected 1 0", start_cnt - s0, fail_cnt - f0); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_retry();
    test_stale_err();
    test_invalid_comma();
    test_reset_mid_wait();
    test_wrap_collision();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
